// File: rtl/audio_stream_reader_pkg.sv
// Shared types and constants for the SD-card audio refill/playback path.
package audio_stream_reader_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_XFER = 2'd2,
    R_DONE = 2'd3
  } refill_state_t;

  localparam int unsigned BLOCK_BYTES_DEF = 512;
  localparam logic [7:0]  SILENCE_DEF     = 8'h80;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_stream_reader_tick_gen.sv
// Free-running strobe generator: one-cycle tick every DIV cycles while enabled.
module audio_stream_reader_tick_gen #(
  parameter int unsigned DIV = 2083
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/audio_stream_reader.sv
// Keeps the audio sample FIFO topped up from SD block reads and pops one
// sample per playback tick towards the PWM stage.
module audio_stream_reader
  import audio_stream_reader_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SAMPLE_HZ    = 48_000,
  parameter int unsigned FIFO_DEPTH   = 2048,
  parameter int unsigned BLOCK_BYTES  = BLOCK_BYTES_DEF,
  parameter int unsigned REFILL_LEVEL = 1024,
  parameter logic [7:0]  SILENCE      = SILENCE_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [31:0]                   start_addr,
  input  logic [31:0]                   end_addr,
  input  logic                          sd_ready,
  input  logic                          sd_byte_available,
  output logic                          sd_rd,
  output logic [31:0]                   sd_adr,
  input  logic [$clog2(FIFO_DEPTH)-1:0] fifo_count,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic [7:0]                    fifo_dout,
  output logic                          fifo_wr_en,
  output logic                          fifo_rd_en,
  output logic [7:0]                    sample_out,
  output logic                          sample_valid,
  output logic                          playing,
  output logic [15:0]                   underrun_count,
  output logic                          overflow
);

  localparam int unsigned DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH);
  localparam int unsigned BC_W  = $clog2(BLOCK_BYTES) + 1;
  localparam logic [CNT_W-1:0] REFILL_LVL = CNT_W'(REFILL_LEVEL);
  localparam logic [BC_W-1:0]  BLOCK_LAST = BC_W'(BLOCK_BYTES);
  localparam logic [31:0]      ADR_STEP   = 32'(BLOCK_BYTES);

  logic          enable_d;
  logic          enable_rise;
  logic [31:0]   start_lat;
  logic          tick;
  logic          vld_p1;
  refill_state_t state, state_next;
  logic [BC_W-1:0] byte_cnt;
  logic [31:0]   adr_sum;
  logic [31:0]   adr_next;

  assign enable_rise = enable && !enable_d;

  // Enable edge detection and play state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_d <= 1'b0;
      playing  <= 1'b0;
    end else begin
      enable_d <= enable;
      playing  <= enable && (playing || enable_rise);
    end
  end

  always_ff @(posedge clk) begin
    if (enable_rise) begin
      start_lat <= start_addr;
    end
  end

  audio_stream_reader_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (playing),
    .tick    (tick)
  );

  // Stage p0: tick issues the pop; stage p1: FIFO data is valid and captured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rd_en     <= 1'b0;
      vld_p1         <= 1'b0;
      sample_out     <= SILENCE;
      sample_valid   <= 1'b0;
      underrun_count <= '0;
    end else begin
      fifo_rd_en   <= tick && !fifo_empty;
      vld_p1       <= fifo_rd_en;
      sample_valid <= 1'b0;
      if (!playing) begin
        sample_out <= SILENCE;
      end else if (vld_p1) begin
        sample_out   <= fifo_dout;
        sample_valid <= 1'b1;
      end else if (tick && fifo_empty) begin
        sample_out     <= SILENCE;
        sample_valid   <= 1'b1;
        underrun_count <= sat_inc16(underrun_count);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= R_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The controller cannot abort, so a started block always runs to completion
  always_comb begin
    state_next = state;
    sd_rd      = 1'b0;
    fifo_wr_en = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (playing && fifo_count <= REFILL_LVL && sd_ready) begin
          state_next = R_REQ;
        end
      end
      R_REQ: begin
        sd_rd = 1'b1;
        if (!sd_ready) begin
          state_next = R_XFER;
        end
      end
      R_XFER: begin
        fifo_wr_en = sd_byte_available && !fifo_full;
        if (byte_cnt == BLOCK_LAST && sd_ready) begin
          state_next = R_DONE;
        end
      end
      R_DONE: begin
        state_next = R_IDLE;
      end
      default: begin
        state_next = R_IDLE;
      end
    endcase
  end

  assign adr_sum  = sd_adr + ADR_STEP;
  assign adr_next = (adr_sum >= end_addr) ? start_lat : adr_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      overflow <= 1'b0;
      sd_adr   <= '0;
    end else begin
      if (state == R_REQ) begin
        byte_cnt <= '0;
      end else if (state == R_XFER && sd_byte_available && byte_cnt != BLOCK_LAST) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (state == R_XFER && sd_byte_available && fifo_full) begin
        overflow <= 1'b1;
      end
      if (enable_rise) begin
        sd_adr <= start_addr;
      end else if (state == R_DONE) begin
        sd_adr <= adr_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_reader.sv
// Bench for audio_stream_reader with behavioural SD-controller and FIFO models.
module tb_audio_stream_reader;

  localparam int DIV = 100_000_000 / 48_000;
  localparam logic [7:0] SIL = 8'h80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_addr = 32'd0;
  logic [31:0] end_addr = 32'd4096;
  logic        sd_ready = 1'b0;
  logic        sd_byte_available = 1'b0;
  logic        sd_rd;
  logic [31:0] sd_adr;
  logic [10:0] fifo_count = 11'd0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'd0;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        playing;
  logic [15:0] underrun_count;
  logic        overflow;

  audio_stream_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .start_addr        (start_addr),
    .end_addr          (end_addr),
    .sd_ready          (sd_ready),
    .sd_byte_available (sd_byte_available),
    .sd_rd             (sd_rd),
    .sd_adr            (sd_adr),
    .fifo_count        (fifo_count),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_dout         (fifo_dout),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_rd_en        (fifo_rd_en),
    .sample_out        (sample_out),
    .sample_valid      (sample_valid),
    .playing           (playing),
    .underrun_count    (underrun_count),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  longint cyc = 0;

  // Controls written only by the test tasks
  bit sd_on = 1'b0;
  bit force_full = 1'b0;
  bit clr = 1'b0;
  int preload_n = 0;

  // Model state written only by the model process
  logic [7:0] fq[$];
  logic [7:0] pop_log[$];
  longint     pop_time[$];
  logic [7:0] samp_log[$];
  logic [31:0] req_q[$];
  logic [7:0] sent_log[$];
  int wr_total = 0;
  int sd_state = 0;
  int sd_sent = 0;
  int sd_gap = 0;
  logic sd_rd_d = 1'b0;
  logic [7:0] sd_dout = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      fq.delete(); pop_log.delete(); pop_time.delete(); samp_log.delete();
      req_q.delete(); sent_log.delete();
      wr_total = 0; sd_state = 0; sd_sent = 0; sd_gap = 0;
      sd_byte_available = 1'b0; sd_ready = 1'b0; sd_rd_d = 1'b0; fifo_dout = 8'd0;
      for (int i = 1; i <= preload_n; i++) fq.push_back(8'(i));
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_dout = fq.pop_front();
        pop_log.push_back(fifo_dout);
        pop_time.push_back(cyc);
      end
      if (fifo_wr_en) begin
        wr_total++;
        if (fq.size() < 2048) fq.push_back(sd_dout);
      end
      if (sample_valid) samp_log.push_back(sample_out);
      if (sd_rd && !sd_rd_d) req_q.push_back(sd_adr);
      sd_rd_d = sd_rd;
      sd_byte_available = 1'b0;
      case (sd_state)
        0: begin
          sd_ready = sd_on;
          if (sd_on && sd_rd) begin
            sd_ready = 1'b0; sd_state = 1; sd_sent = 0; sd_gap = $urandom_range(1, 3);
          end
        end
        1: begin
          if (sd_gap > 0) sd_gap--;
          else begin
            sd_byte_available = 1'b1;
            sd_dout = 8'($urandom);
            sent_log.push_back(sd_dout);
            sd_sent++;
            sd_gap = $urandom_range(0, 2);
            if (sd_sent == 512) begin sd_state = 2; sd_gap = 2; end
          end
        end
        default: begin
          if (sd_gap > 0) sd_gap--;
          else begin sd_ready = 1'b1; sd_state = 0; end
        end
      endcase
    end
    fifo_count = 11'(fq.size());
    fifo_full  = force_full || (fq.size() >= 2048);
    fifo_empty = (fq.size() == 0);
  end

  task automatic do_reset(input int preload);
    enable = 1'b0; sd_on = 1'b0; force_full = 1'b0; preload_n = preload;
    clr = 1'b1; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(0);
    n_checks++;
    if ({sd_rd, fifo_wr_en, fifo_rd_en, sample_valid, playing, overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {sd_rd, fifo_wr_en, fifo_rd_en, sample_valid, playing, overflow});
    end
    n_checks++;
    if (sample_out !== SIL) begin n_fail++; $display("FAIL reset_sample: got %h expected %h", sample_out, SIL); end
    n_checks++;
    if (sd_adr !== 32'd0) begin n_fail++; $display("FAIL reset_adr: got %h expected 0", sd_adr); end
    n_checks++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL reset_underrun: got %0d expected 0", underrun_count); end
    sd_on = 1'b1;
    repeat (10000) @(negedge clk);
    n_checks++;
    if (samp_log.size() != 0) begin n_fail++; $display("FAIL idle_valid: got %0d samples expected 0", samp_log.size()); end
    n_checks++;
    if (req_q.size() != 0) begin n_fail++; $display("FAIL idle_rd: got %0d requests expected 0", req_q.size()); end
    n_checks++;
    if (sample_out !== SIL) begin n_fail++; $display("FAIL idle_sample: got %h expected %h", sample_out, SIL); end
  endtask

  task automatic test_refill();
    int t;
    int n;
    do_reset(0);
    start_addr = 32'd0; end_addr = 32'd4096; sd_on = 1'b1; enable = 1'b1;
    for (t = 0; t < 20000 && (req_q.size() < 2 || samp_log.size() < 4); t++) @(negedge clk);
    n_checks++;
    if (req_q.size() < 2 || samp_log.size() < 4) begin
      n_fail++; $display("FAIL refill_timeout: got %0d requests %0d samples expected 2 and 4", req_q.size(), samp_log.size());
    end else begin
      n_checks++;
      if (req_q[0] !== 32'd0) begin n_fail++; $display("FAIL refill_adr0: got %h expected 0", req_q[0]); end
      n_checks++;
      if (req_q[1] !== 32'd512) begin n_fail++; $display("FAIL refill_adr1: got %h expected 200", req_q[1]); end
      n = (pop_log.size() < sent_log.size()) ? pop_log.size() : sent_log.size();
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (pop_log[i] !== sent_log[i]) begin
          n_fail++; $display("FAIL refill_fifo_order[%0d]: got %h expected %h", i, pop_log[i], sent_log[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (i >= sent_log.size() || samp_log[i] !== sent_log[i]) begin
          n_fail++; $display("FAIL refill_sample[%0d]: got %h expected stream byte", i, samp_log[i]);
        end
      end
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL refill_overflow: got %b expected 0", overflow); end
    if (sent_log.size() >= 512) begin
      n_checks++;
      if (wr_total < 512) begin n_fail++; $display("FAIL refill_wr_count: got %0d expected >=512", wr_total); end
    end
  endtask

  task automatic test_tick_rate();
    int t;
    do_reset(16);
    enable = 1'b1;
    for (t = 0; t < 17 * DIV + 2000 && pop_time.size() < 16; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks++;
    if (pop_time.size() != 16 || samp_log.size() != 16) begin
      n_fail++; $display("FAIL tick_timeout: got %0d pops %0d samples expected 16", pop_time.size(), samp_log.size());
    end else begin
      for (int i = 1; i < 16; i++) begin
        n_checks++;
        if (pop_time[i] - pop_time[i-1] != longint'(DIV)) begin
          n_fail++; $display("FAIL tick_period[%0d]: got %0d expected %0d", i, pop_time[i] - pop_time[i-1], DIV);
        end
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (samp_log[i] !== 8'(i + 1)) begin
          n_fail++; $display("FAIL tick_sample[%0d]: got %h expected %h", i, samp_log[i], 8'(i + 1));
        end
      end
    end
    n_checks++;
    if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL tick_underrun: got %0d expected 0", underrun_count); end
  endtask

  task automatic test_underrun();
    int t;
    for (t = 0; t < 4 * DIV && samp_log.size() < 19; t++) @(negedge clk);
    n_checks++;
    if (samp_log.size() < 19) begin
      n_fail++; $display("FAIL underrun_timeout: got %0d samples expected 19", samp_log.size());
    end else begin
      for (int i = 16; i < 19; i++) begin
        n_checks++;
        if (samp_log[i] !== SIL) begin n_fail++; $display("FAIL underrun_sample[%0d]: got %h expected %h", i, samp_log[i], SIL); end
      end
      n_checks++;
      if (underrun_count !== 16'd3) begin n_fail++; $display("FAIL underrun_count: got %0d expected 3", underrun_count); end
      n_checks++;
      if (pop_time.size() != 16) begin n_fail++; $display("FAIL underrun_pop: got %0d pops expected 16", pop_time.size()); end
    end
  endtask

  task automatic test_wrap();
    int t;
    logic [31:0] base;
    do_reset(0);
    base = 32'($urandom_range(0, 100)) * 32'd512;
    start_addr = base; end_addr = base + 32'd1024; sd_on = 1'b1; enable = 1'b1;
    for (t = 0; t < 20000 && req_q.size() < 3; t++) @(negedge clk);
    n_checks++;
    if (req_q.size() < 3) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d requests expected 3", req_q.size());
    end else begin
      n_checks++;
      if (req_q[0] !== base || req_q[1] !== base + 32'd512 || req_q[2] !== base) begin
        n_fail++; $display("FAIL wrap_adr: got %h %h %h expected %h %h %h", req_q[0], req_q[1], req_q[2],
                           base, base + 32'd512, base);
      end
    end
  endtask

  task automatic test_overflow();
    int t;
    do_reset(0);
    start_addr = 32'd0; end_addr = 32'd4096; sd_on = 1'b1; enable = 1'b1;
    for (t = 0; t < 100 && req_q.size() < 1; t++) @(negedge clk);
    force_full = 1'b1;
    for (t = 0; t < 5000 && req_q.size() < 2; t++) @(negedge clk);
    n_checks++;
    if (req_q.size() < 2) begin n_fail++; $display("FAIL overflow_timeout: got %0d requests expected 2", req_q.size()); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
    n_checks++;
    if (wr_total != 0) begin n_fail++; $display("FAIL overflow_wr: got %0d writes expected 0", wr_total); end
    force_full = 1'b0;
  endtask

  task automatic test_enable_drop();
    int t;
    do_reset(0);
    start_addr = 32'd0; end_addr = 32'd4096; sd_on = 1'b1; enable = 1'b1;
    for (t = 0; t < 3000 && sd_sent < 100; t++) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (playing !== 1'b0) begin n_fail++; $display("FAIL drop_playing: got %b expected 0", playing); end
    repeat (3000) @(negedge clk);
    n_checks++;
    if (wr_total != 512) begin n_fail++; $display("FAIL drop_wr: got %0d writes expected 512", wr_total); end
    n_checks++;
    if (req_q.size() != 1) begin n_fail++; $display("FAIL drop_rd: got %0d requests expected 1", req_q.size()); end
    n_checks++;
    if (sample_out !== SIL) begin n_fail++; $display("FAIL drop_sample: got %h expected %h", sample_out, SIL); end
  endtask

  task automatic test_async_reset();
    int t;
    int snap;
    do_reset(0);
    start_addr = 32'd2560; end_addr = 32'd8192; sd_on = 1'b1; enable = 1'b1;
    for (t = 0; t < 3000 && sd_sent < 50; t++) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({sd_rd, fifo_wr_en, fifo_rd_en, sample_valid, playing} !== 5'b0) begin
      n_fail++; $display("FAIL areset_ctrl: got %b expected 00000", {sd_rd, fifo_wr_en, fifo_rd_en, sample_valid, playing});
    end
    n_checks++;
    if (sd_adr !== 32'd0 || sample_out !== SIL) begin
      n_fail++; $display("FAIL areset_data: got adr %h sample %h expected 0 and %h", sd_adr, sample_out, SIL);
    end
    snap = wr_total;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_total != snap) begin n_fail++; $display("FAIL areset_wr: got %0d writes expected %0d", wr_total, snap); end
    do_reset(0);
  endtask

  initial begin
    test_reset();
    test_refill();
    test_tick_rate();
    test_underrun();
    test_wrap();
    test_overflow();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
